// File: rtl/lane_vrf_write_arbiter.sv
// rtl/lane_vrf_write_arbiter.sv - round-robin arbiter sharing one lane VRF write port
// Grants one requester per cycle into a small FIFO that drives the VRF write handshake.
module lane_vrf_write_arbiter #(
  parameter int REQ_NUM = 3,
  parameter int DEPTH   = 2
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic [REQ_NUM-1:0]    req_valid,
  output logic [REQ_NUM-1:0]    req_ready,
  input  logic [5*REQ_NUM-1:0]  req_vd,
  input  logic [REQ_NUM-1:0]    req_offset,
  input  logic [4*REQ_NUM-1:0]  req_mask,
  input  logic [32*REQ_NUM-1:0] req_data,
  input  logic [REQ_NUM-1:0]    req_last,
  input  logic [3*REQ_NUM-1:0]  req_instructionIndex,
  input  logic                  vrfWriteRequest_ready,
  output logic                  vrfWriteRequest_valid,
  output logic [4:0]            vrfWriteRequest_bits_vd,
  output logic                  vrfWriteRequest_bits_offset,
  output logic [3:0]            vrfWriteRequest_bits_mask,
  output logic [31:0]           vrfWriteRequest_bits_data,
  output logic                  vrfWriteRequest_bits_last,
  output logic [2:0]            vrfWriteRequest_bits_instructionIndex,
  output logic                  commit_valid,
  output logic [2:0]            commit_instructionIndex,
  output logic [7:0]            writePending
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int RRW = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
  localparam int EW  = 46;

  logic [RRW-1:0] r_rr;
  logic [PW-1:0]  r_wr;
  logic [PW-1:0]  r_rd;
  logic [CW-1:0]  r_count;
  logic [EW-1:0]  r_mem [DEPTH];

  logic           w_space;
  logic           w_hi_found;
  logic           w_lo_found;
  logic [RRW-1:0] w_hi_idx;
  logic [RRW-1:0] w_lo_idx;
  logic [RRW-1:0] w_gidx;
  logic [RRW-1:0] w_rr_next;
  logic           w_fire;
  logic           w_push;
  logic           w_pop;
  logic [EW-1:0]  w_entry;
  logic [EW-1:0]  w_head;
  logic [PW-1:0]  w_rel;
  logic [7:0]     w_pend;

  // Space is judged on registered count only, so a same-cycle pop never frees a slot.
  assign w_space = (r_count < CW'(DEPTH));

  // Descending scan leaves the lowest index at or above rrPtr (hi) and below it (lo).
  always_comb begin
    w_hi_found = 1'b0;
    w_lo_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    for (int i = REQ_NUM - 1; i >= 0; i--) begin
      if (req_valid[i] && (i >= int'(r_rr))) begin
        w_hi_found = 1'b1;
        w_hi_idx   = RRW'(i);
      end
      if (req_valid[i] && (i < int'(r_rr))) begin
        w_lo_found = 1'b1;
        w_lo_idx   = RRW'(i);
      end
    end
  end

  assign w_gidx    = w_hi_found ? w_hi_idx : w_lo_idx;
  assign w_fire    = rst_n & w_space & (w_hi_found | w_lo_found);
  assign w_rr_next = (w_gidx == RRW'(REQ_NUM - 1)) ? '0 : (w_gidx + RRW'(1));

  always_comb begin
    req_ready = '0;
    w_entry   = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      req_ready[i] = w_fire && (w_gidx == RRW'(i));
      if (w_gidx == RRW'(i)) begin
        w_entry = {req_vd[5*i +: 5], req_offset[i], req_mask[4*i +: 4],
                   req_data[32*i +: 32], req_last[i], req_instructionIndex[3*i +: 3]};
      end
    end
  end

  // Empty-mask, non-last writes carry nothing for the VRF and are swallowed at grant.
  assign w_push = w_fire & ((w_entry[39:36] != 4'd0) | w_entry[3]);
  assign w_head = r_mem[r_rd];
  assign w_pop  = (r_count != '0) & vrfWriteRequest_ready;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_rr    <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_fire) r_rr <= w_rr_next;
      if (w_push) r_wr <= r_wr + PW'(1);
      if (w_pop)  r_rd <= r_rd + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr] <= w_entry;
  end

  always_comb begin
    w_pend = '0;
    w_rel  = '0;
    for (int d = 0; d < DEPTH; d++) begin
      w_rel = PW'(d) - r_rd;
      if (CW'(w_rel) < r_count) w_pend[r_mem[d][2:0]] = 1'b1;
    end
  end

  assign writePending                          = w_pend;
  assign vrfWriteRequest_valid                 = (r_count != '0);
  assign vrfWriteRequest_bits_vd               = w_head[45:41];
  assign vrfWriteRequest_bits_offset           = w_head[40];
  assign vrfWriteRequest_bits_mask             = w_head[39:36];
  assign vrfWriteRequest_bits_data             = w_head[35:4];
  assign vrfWriteRequest_bits_last             = w_head[3];
  assign vrfWriteRequest_bits_instructionIndex = w_head[2:0];
  assign commit_valid                          = w_pop & w_head[3];
  assign commit_instructionIndex               = w_head[2:0];

endmodule

// File: tb/tb_lane_vrf_write_arbiter.sv
// tb/tb_lane_vrf_write_arbiter.sv - directed self-checking bench for lane_vrf_write_arbiter
`timescale 1ns/1ps
module tb_lane_vrf_write_arbiter;

  logic        clock = 1'b0;
  logic        rst_n;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [14:0] req_vd;
  logic [2:0]  req_offset;
  logic [11:0] req_mask;
  logic [95:0] req_data;
  logic [2:0]  req_last;
  logic [8:0]  req_idx;
  logic        vrf_rdy;
  logic        vrf_vld;
  logic [4:0]  o_vd;
  logic        o_off;
  logic [3:0]  o_mask;
  logic [31:0] o_data;
  logic        o_last;
  logic [2:0]  o_idx;
  logic        cm_vld;
  logic [2:0]  cm_idx;
  logic [7:0]  wp;

  int n_cmp = 0;
  int n_bad = 0;

  always #10 clock = ~clock;

  lane_vrf_write_arbiter #(.REQ_NUM(3), .DEPTH(2)) dut (
    .clock(clock), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_vd(req_vd),
    .req_offset(req_offset), .req_mask(req_mask), .req_data(req_data),
    .req_last(req_last), .req_instructionIndex(req_idx),
    .vrfWriteRequest_ready(vrf_rdy), .vrfWriteRequest_valid(vrf_vld),
    .vrfWriteRequest_bits_vd(o_vd), .vrfWriteRequest_bits_offset(o_off),
    .vrfWriteRequest_bits_mask(o_mask), .vrfWriteRequest_bits_data(o_data),
    .vrfWriteRequest_bits_last(o_last), .vrfWriteRequest_bits_instructionIndex(o_idx),
    .commit_valid(cm_vld), .commit_instructionIndex(cm_idx), .writePending(wp)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int i, input logic [4:0] vd, input logic off, input logic [3:0] m,
                         input logic [31:0] d, input logic l, input logic [2:0] ix);
    req_vd[5*i +: 5]   = vd;
    req_offset[i]      = off;
    req_mask[4*i +: 4] = m;
    req_data[32*i +: 32] = d;
    req_last[i]        = l;
    req_idx[3*i +: 3]  = ix;
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0; req_valid = '0; vrf_rdy = 1'b0;
    req_vd = '0; req_offset = '0; req_mask = '0; req_data = '0; req_last = '0; req_idx = '0;
    @(negedge clock);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 3'b111; vrf_rdy = 1'b1;
    req_vd = '0; req_offset = '0; req_mask = 12'hFFF; req_data = '0; req_last = '0; req_idx = '0;
    @(posedge clock); @(posedge clock); @(negedge clock);
    n_cmp++; if (req_ready !== 3'b000) begin n_bad++; $display("FAIL reset_ready got %b want 000", req_ready); end
    n_cmp++; if (vrf_vld !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", vrf_vld); end
    n_cmp++; if (wp !== 8'h00) begin n_bad++; $display("FAIL reset_pending got %h want 00", wp); end
    n_cmp++; if (cm_vld !== 1'b0) begin n_bad++; $display("FAIL reset_commit got %b want 0", cm_vld); end
    rst_n = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 3'b001) begin n_bad++; $display("FAIL reset_first_grant got %b want 001", req_ready); end
    req_valid = '0;
  endtask

  task automatic test_single();
    do_reset();
    vrf_rdy = 1'b1;
    set_req(0, 5'd3, 1'b1, 4'hF, 32'hDEADBEEF, 1'b0, 3'd2);
    req_valid = 3'b001;
    @(negedge clock);
    n_cmp++; if (req_ready !== 3'b001) begin n_bad++; $display("FAIL single_ready got %b want 001", req_ready); end
    n_cmp++; if (vrf_vld !== 1'b0) begin n_bad++; $display("FAIL single_pre_valid got %b want 0", vrf_vld); end
    tick();
    req_valid = '0;
    @(negedge clock);
    n_cmp++; if (vrf_vld !== 1'b1) begin n_bad++; $display("FAIL single_valid got %b want 1", vrf_vld); end
    n_cmp++; if ({o_vd, o_off, o_mask, o_data, o_last, o_idx} !== {5'd3, 1'b1, 4'hF, 32'hDEADBEEF, 1'b0, 3'd2}) begin
      n_bad++; $display("FAIL single_fields got %h/%b/%h/%h/%b/%h want 03/1/f/deadbeef/0/2", o_vd, o_off, o_mask, o_data, o_last, o_idx);
    end
    n_cmp++; if (wp !== 8'h04) begin n_bad++; $display("FAIL single_pending got %h want 04", wp); end
    n_cmp++; if (cm_vld !== 1'b0) begin n_bad++; $display("FAIL single_commit got %b want 0", cm_vld); end
    tick();
    @(negedge clock);
    n_cmp++; if (vrf_vld !== 1'b0) begin n_bad++; $display("FAIL single_drained got %b want 0", vrf_vld); end
    n_cmp++; if (wp !== 8'h00) begin n_bad++; $display("FAIL single_pending_clear got %h want 00", wp); end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_rdy;
    logic [31:0] exp_d;
    do_reset();
    vrf_rdy = 1'b1;
    for (int i = 0; i < 3; i++) set_req(i, 5'(i + 8), 1'b0, 4'hF, 32'h1000_0000 + 32'(i), 1'b0, 3'(i));
    req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      exp_rdy = 3'b001 << (k % 3);
      n_cmp++; if (req_ready !== exp_rdy) begin n_bad++; $display("FAIL rr_grant[%0d] got %b want %b", k, req_ready, exp_rdy); end
      if (k > 0) begin
        exp_d = 32'h1000_0000 + 32'((k - 1) % 3);
        n_cmp++; if (vrf_vld !== 1'b1 || o_data !== exp_d) begin
          n_bad++; $display("FAIL rr_head[%0d] got %b/%h want 1/%h", k, vrf_vld, o_data, exp_d);
        end
      end
      tick();
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    vrf_rdy = 1'b0;
    set_req(1, 5'd4, 1'b0, 4'h1, 32'hA0, 1'b0, 3'd1);
    req_valid = 3'b010;
    @(negedge clock);
    n_cmp++; if (req_ready !== 3'b010) begin n_bad++; $display("FAIL bp_fire1 got %b want 010", req_ready); end
    tick(); req_data[63:32] = 32'hA1;
    @(negedge clock);
    n_cmp++; if (req_ready !== 3'b010) begin n_bad++; $display("FAIL bp_fire2 got %b want 010", req_ready); end
    tick(); req_data[63:32] = 32'hA2;
    @(negedge clock);
    n_cmp++; if (req_ready !== 3'b000) begin n_bad++; $display("FAIL bp_full got %b want 000", req_ready); end
    tick();
    @(negedge clock);
    n_cmp++; if (req_ready !== 3'b000 || o_data !== 32'hA0) begin
      n_bad++; $display("FAIL bp_full_head got %b/%h want 000/a0", req_ready, o_data);
    end
    vrf_rdy = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 3'b000) begin n_bad++; $display("FAIL bp_full_pop_ready got %b want 000", req_ready); end
    tick(); vrf_rdy = 1'b0;
    @(negedge clock);
    n_cmp++; if (req_ready !== 3'b010 || o_data !== 32'hA1) begin
      n_bad++; $display("FAIL bp_return got %b/%h want 010/a1", req_ready, o_data);
    end
    tick(); req_valid = '0;
    @(negedge clock);
    n_cmp++; if (vrf_vld !== 1'b1 || o_data !== 32'hA1) begin
      n_bad++; $display("FAIL bp_order1 got %b/%h want 1/a1", vrf_vld, o_data);
    end
    vrf_rdy = 1'b1;
    tick();
    @(negedge clock);
    n_cmp++; if (vrf_vld !== 1'b1 || o_data !== 32'hA2) begin
      n_bad++; $display("FAIL bp_order2 got %b/%h want 1/a2", vrf_vld, o_data);
    end
    tick();
    @(negedge clock);
    n_cmp++; if (vrf_vld !== 1'b0) begin n_bad++; $display("FAIL bp_empty got %b want 0", vrf_vld); end
    vrf_rdy = 1'b0;
  endtask

  task automatic test_mask_zero();
    do_reset();
    vrf_rdy = 1'b1;
    set_req(0, 5'd1, 1'b0, 4'h0, 32'h55, 1'b0, 3'd3);
    req_valid = 3'b001;
    @(negedge clock);
    n_cmp++; if (req_ready !== 3'b001) begin n_bad++; $display("FAIL mz_fire got %b want 001", req_ready); end
    tick();
    set_req(0, 5'd2, 1'b0, 4'hF, 32'h66, 1'b0, 3'd4);
    set_req(1, 5'd5, 1'b1, 4'h0, 32'h77, 1'b1, 3'd5);
    req_valid = 3'b011;
    @(negedge clock);
    n_cmp++; if (vrf_vld !== 1'b0 || wp !== 8'h00) begin
      n_bad++; $display("FAIL mz_dropped got %b/%h want 0/00", vrf_vld, wp);
    end
    n_cmp++; if (req_ready !== 3'b010) begin n_bad++; $display("FAIL mz_rr_advance got %b want 010", req_ready); end
    tick(); req_valid = '0;
    @(negedge clock);
    n_cmp++; if (vrf_vld !== 1'b1 || o_vd !== 5'd5 || o_mask !== 4'h0 || o_last !== 1'b1 || wp !== 8'h20) begin
      n_bad++; $display("FAIL mz_last_emit got %b/%h/%h/%b/%h want 1/05/0/1/20", vrf_vld, o_vd, o_mask, o_last, wp);
    end
    n_cmp++; if (cm_vld !== 1'b1 || cm_idx !== 3'd5) begin
      n_bad++; $display("FAIL mz_commit got %b/%0d want 1/5", cm_vld, cm_idx);
    end
    tick();
    @(negedge clock);
    n_cmp++; if (vrf_vld !== 1'b0 || cm_vld !== 1'b0) begin
      n_bad++; $display("FAIL mz_after got %b/%b want 0/0", vrf_vld, cm_vld);
    end
  endtask

  task automatic test_commit_stall();
    do_reset();
    vrf_rdy = 1'b0;
    set_req(2, 5'd9, 1'b0, 4'h3, 32'h00C0FFEE, 1'b1, 3'd7);
    req_valid = 3'b100;
    @(negedge clock);
    n_cmp++; if (req_ready !== 3'b100) begin n_bad++; $display("FAIL cs_fire got %b want 100", req_ready); end
    tick(); req_valid = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      n_cmp++; if (vrf_vld !== 1'b1 || cm_vld !== 1'b0 || wp !== 8'h80) begin
        n_bad++; $display("FAIL cs_stall[%0d] got %b/%b/%h want 1/0/80", k, vrf_vld, cm_vld, wp);
      end
      tick();
    end
    vrf_rdy = 1'b1;
    @(negedge clock);
    n_cmp++; if (cm_vld !== 1'b1 || cm_idx !== 3'd7 || wp !== 8'h80) begin
      n_bad++; $display("FAIL cs_pulse got %b/%0d/%h want 1/7/80", cm_vld, cm_idx, wp);
    end
    tick(); vrf_rdy = 1'b0;
    @(negedge clock);
    n_cmp++; if (cm_vld !== 1'b0 || vrf_vld !== 1'b0 || wp !== 8'h00) begin
      n_bad++; $display("FAIL cs_after got %b/%b/%h want 0/0/00", cm_vld, vrf_vld, wp);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    vrf_rdy = 1'b0;
    set_req(0, 5'd1, 1'b0, 4'hF, 32'h11, 1'b1, 3'd1);
    req_valid = 3'b001;
    @(negedge clock);
    n_cmp++; if (req_ready !== 3'b001) begin n_bad++; $display("FAIL ar_fire1 got %b want 001", req_ready); end
    tick();
    set_req(0, 5'd2, 1'b0, 4'hF, 32'h22, 1'b1, 3'd6);
    @(negedge clock);
    n_cmp++; if (req_ready !== 3'b001) begin n_bad++; $display("FAIL ar_fire2 got %b want 001", req_ready); end
    tick(); req_valid = '0;
    @(negedge clock);
    n_cmp++; if (vrf_vld !== 1'b1 || wp !== 8'h42) begin
      n_bad++; $display("FAIL ar_buffered got %b/%h want 1/42", vrf_vld, wp);
    end
    #1 vrf_rdy = 1'b1;
    #1;
    n_cmp++; if (cm_vld !== 1'b1 || cm_idx !== 3'd1) begin
      n_bad++; $display("FAIL ar_pre_commit got %b/%0d want 1/1", cm_vld, cm_idx);
    end
    rst_n = 1'b0; req_valid = 3'b111;
    #1;
    n_cmp++; if (vrf_vld !== 1'b0 || wp !== 8'h00 || cm_vld !== 1'b0 || req_ready !== 3'b000) begin
      n_bad++; $display("FAIL ar_in_reset got %b/%h/%b/%b want 0/00/0/000", vrf_vld, wp, cm_vld, req_ready);
    end
    vrf_rdy = 1'b0;
    #1 rst_n = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 3'b001) begin n_bad++; $display("FAIL ar_first_grant got %b want 001", req_ready); end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_mask_zero();
    test_commit_stall();
    test_async_reset();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
